apb_arbiter_master: RTL and testbench

APB master front-end that lets `NUM_REQ` local requesters share one APB bus. Each requester presents a single read or write with a valid/ready handshake. The block picks requesters round-robin and sequences the APB SETUP and ACCESS phases on `psel`, `penable`, `pwrite`, `paddr` and `pwdata`. It returns a per-requester completion pulse with read data. It drives the same signal set as the team's APB bus interface, which has no `pready` and no `pslverr`, so every ACCESS phase completes in exactly one cycle.

---
 rtl/apb_arbiter_master.sv | 126 ++++++++++++
 tb/tb_apb_arbiter_master.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_arbiter_master.sv
// APB master front-end: round-robin arbitration of NUM_REQ requesters
// onto one APB bus (no pready/pslverr, fixed one-cycle ACCESS).
// Ports: pclk/preset (sync, active-high); req_valid/write/addr/wdata in,
//   req_ready out (combinational grant); rsp_valid/rsp_rdata (registered);
//   psel/penable/pwrite/paddr/pwdata out, prdata in.
module apb_arbiter_master #(
  parameter int NUM_REQ   = 4,
  parameter int ADDRWIDTH = 8,
  parameter int DATAWIDTH = 32
) (
  input  logic                           pclk,
  input  logic                           preset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDRWIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATAWIDTH-1:0]           rsp_rdata,
  output logic                           psel,
  output logic                           penable,
  output logic                           pwrite,
  output logic [ADDRWIDTH-1:0]           paddr,
  output logic [DATAWIDTH-1:0]           pwdata,
  input  logic [DATAWIDTH-1:0]           prdata
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state;
  state_t state_nx;

  logic [IW-1:0] last;
  logic [IW-1:0] owner;
  logic [IW-1:0] win;
  logic [IW-1:0] sel;
  int            rr_idx;
  logic          any_req;
  logic          window;
  logic          accept;

  // First valid requester at or after last+1, wrapping.
  always_comb begin
    win     = '0;
    sel     = '0;
    rr_idx  = 0;
    any_req = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = int'(last) + k;
      if (rr_idx >= NUM_REQ) rr_idx -= NUM_REQ;
      sel = IW'(rr_idx);
      if (!any_req && req_valid[sel]) begin
        win     = sel;
        any_req = 1'b1;
      end
    end
  end

  // Grants are only offered when the bus can take a new SETUP next cycle.
  assign window = !preset && (state == IDLE || state == ACCESS);
  assign accept = window && any_req;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  always_ff @(posedge pclk) begin
    if (preset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    psel     = 1'b0;
    penable  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = SETUP;
      end
      SETUP: begin
        psel     = 1'b1;
        state_nx = ACCESS;
      end
      ACCESS: begin
        psel     = 1'b1;
        penable  = 1'b1;
        state_nx = accept ? SETUP : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      last      <= IW'(NUM_REQ - 1);
      owner     <= '0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= '0;
      // pwrite/owner still describe the finishing transfer here.
      if (state == ACCESS) begin
        rsp_valid[owner] <= 1'b1;
        rsp_rdata        <= pwrite ? '0 : prdata;
      end
      if (accept) begin
        pwrite <= req_write[win];
        paddr  <= req_addr[win*ADDRWIDTH +: ADDRWIDTH];
        pwdata <= req_wdata[win*DATAWIDTH +: DATAWIDTH];
        owner  <= win;
        last   <= win;
      end
    end
  end

endmodule

// File: tb/tb_apb_arbiter_master.sv
// Testbench for apb_arbiter_master: table vectors, directed corner
// sequences and random traffic against a transaction-timeline model.
module tb_apb_arbiter_master;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;

  logic              pclk = 1'b0;
  logic              preset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_write;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic [DW-1:0]     prdata;

  always #5 pclk = ~pclk;

  apb_arbiter_master #(
    .NUM_REQ(N),
    .ADDRWIDTH(AW),
    .DATAWIDTH(DW)
  ) dut (
    .pclk(pclk),
    .preset(preset),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
    .paddr(paddr),
    .pwdata(pwdata),
    .prdata(prdata)
  );

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  // Model: which requester was accepted 1, 2 and 3 cycles ago.
  typedef struct {
    bit            v;
    int            who;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } acc_t;

  acc_t          h1, h2, h3;
  int            m_last = N - 1;
  logic          m_pwrite;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pwdata;
  logic [DW-1:0] m_rdata;
  logic [N-1:0]  e_ready;
  int            win_m;

  typedef struct {
    logic [N-1:0]  valid;
    logic [DW-1:0] rd;
    logic [N-1:0]  ready;
    bit            psel;
    bit            pen;
    logic [N-1:0]  rsp;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int lst);
    logic [N-1:0] s;
    int j;
    for (int k = 1; k <= N; k++) begin
      j = (lst + k) % N;
      s = v >> j;
      if (s[0]) return j;
    end
    return -1;
  endfunction

  task automatic settle();
    #2;
    if (preset || h1.v) win_m = -1;
    else                win_m = rr_pick(req_valid, m_last);
    e_ready = '0;
    if (win_m >= 0) e_ready = 4'b0001 << win_m;
    if (checking) begin
      chk("req_ready", req_ready, e_ready);
      chk("psel", psel, h1.v || h2.v);
      chk("penable", penable, h2.v);
      chk("pwrite", pwrite, m_pwrite);
      chk("paddr", paddr, m_paddr);
      chk("pwdata", pwdata, m_pwdata);
      chk("rsp_valid", rsp_valid, h3.v ? (4'b0001 << h3.who) : 4'b0000);
      chk("rsp_rdata", rsp_rdata, m_rdata);
    end
  endtask

  task automatic adv();
    acc_t         nw;
    logic [N-1:0]    tw;
    logic [N*AW-1:0] ta;
    logic [N*DW-1:0] td;
    nw = '{default: '0};
    if (preset) begin
      h1 = '{default: '0};
      h2 = '{default: '0};
      h3 = '{default: '0};
      m_last   = N - 1;
      m_pwrite = 1'b0;
      m_paddr  = '0;
      m_pwdata = '0;
      m_rdata  = '0;
    end else begin
      if (h2.v) m_rdata = h2.wr ? '0 : prdata;
      if (win_m >= 0) begin
        tw = req_write >> win_m;
        ta = req_addr >> (win_m * AW);
        td = req_wdata >> (win_m * DW);
        nw.v    = 1'b1;
        nw.who  = win_m;
        nw.wr   = tw[0];
        nw.addr = ta[AW-1:0];
        nw.wd   = td[DW-1:0];
        m_pwrite = nw.wr;
        m_paddr  = nw.addr;
        m_pwdata = nw.wd;
        m_last   = win_m;
      end
      h3 = h2;
      h2 = h1;
      h1 = nw;
    end
    @(posedge pclk);
    @(negedge pclk);
  endtask

  task automatic cyc();
    settle();
    adv();
  endtask

  task automatic set_req(input int i, input bit v, input bit w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_write[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    preset = 1'b1;
    cyc();
    preset = 1'b0;
  endtask

  logic [N-1:0] granted;

  initial begin
    tbl[0] = '{4'hF, 32'h1000, 4'b0001, 0, 0, 4'b0000, 8'h00, 32'h0};
    tbl[1] = '{4'hF, 32'h1001, 4'b0000, 1, 0, 4'b0000, 8'h20, 32'h0};
    tbl[2] = '{4'hF, 32'h1002, 4'b0010, 1, 1, 4'b0000, 8'h20, 32'h0};
    tbl[3] = '{4'hF, 32'h1003, 4'b0000, 1, 0, 4'b0001, 8'h21, 32'h1002};
    tbl[4] = '{4'hF, 32'h1004, 4'b0100, 1, 1, 4'b0000, 8'h21, 32'h1002};
    tbl[5] = '{4'hF, 32'h1005, 4'b0000, 1, 0, 4'b0010, 8'h22, 32'h0};
    tbl[6] = '{4'hF, 32'h1006, 4'b1000, 1, 1, 4'b0000, 8'h22, 32'h0};
    tbl[7] = '{4'hF, 32'h1007, 4'b0000, 1, 0, 4'b0100, 8'h23, 32'h1006};
    tbl[8] = '{4'hF, 32'h1008, 4'b0001, 1, 1, 4'b0000, 8'h23, 32'h1006};
    tbl[9] = '{4'hF, 32'h1009, 4'b0000, 1, 0, 4'b1000, 8'h20, 32'h0};

    preset = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr = '0;
    req_wdata = '0;
    prdata = '0;
    @(negedge pclk);
    cyc();
    checking = 1'b1;

    // Reset state while requests are pending.
    req_valid = 4'hF;
    settle();
    chk("rst_ready", req_ready, 0);
    chk("rst_psel", psel, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    adv();
    preset = 1'b0;

    // All four valid from reset: requester i writes when i is odd.
    for (int i = 0; i < N; i++)
      set_req(i, 1'b1, i[0], 8'(32'h20 + i), 32'hC0DE0000 + i);
    for (int c = 0; c < 10; c++) begin
      req_valid = tbl[c].valid;
      prdata = tbl[c].rd;
      settle();
      chk("tbl_ready", req_ready, tbl[c].ready);
      chk("tbl_psel", psel, tbl[c].psel);
      chk("tbl_penable", penable, tbl[c].pen);
      chk("tbl_rsp", rsp_valid, tbl[c].rsp);
      chk("tbl_paddr", paddr, tbl[c].addr);
      chk("tbl_rdata", rsp_rdata, tbl[c].rdata);
      adv();
    end
    req_valid = '0;
    cyc();
    cyc();
    cyc();

    // Single read by requester 2.
    do_reset();
    set_req(2, 1'b1, 1'b0, 8'h10, 32'h0);
    prdata = '0;
    settle();
    chk("rd_ready", req_ready, 4'b0100);
    adv();
    req_valid = '0;
    settle();
    chk("rd_psel", psel, 1);
    chk("rd_pen_setup", penable, 0);
    chk("rd_paddr", paddr, 8'h10);
    chk("rd_pwrite", pwrite, 0);
    adv();
    prdata = 32'hDEADBEEF;
    settle();
    chk("rd_pen_access", penable, 1);
    adv();
    prdata = '0;
    settle();
    chk("rd_rsp", rsp_valid, 4'b0100);
    chk("rd_rdata", rsp_rdata, 32'hDEADBEEF);
    adv();

    // Single write by requester 0.
    set_req(0, 1'b1, 1'b1, 8'h04, 32'hA5A5A5A5);
    prdata = 32'h12345678;
    settle();
    chk("wr_ready", req_ready, 4'b0001);
    adv();
    req_valid = '0;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("wr_pwrite", pwrite, 1);
      chk("wr_pwdata", pwdata, 32'hA5A5A5A5);
      chk("wr_paddr", paddr, 8'h04);
      adv();
    end
    settle();
    chk("wr_rsp", rsp_valid, 4'b0001);
    chk("wr_rdata", rsp_rdata, 0);
    adv();

    // Bring last to 1, then 1 and 3 compete.
    set_req(1, 1'b1, 1'b0, 8'h31, 32'h0);
    cyc();
    req_valid = '0;
    cyc();
    cyc();
    cyc();
    set_req(1, 1'b1, 1'b1, 8'h41, 32'h11);
    set_req(3, 1'b1, 1'b1, 8'h43, 32'h33);
    settle();
    chk("rr_first", req_ready, 4'b1000);
    adv();
    req_valid[3] = 1'b0;
    cyc();
    settle();
    chk("rr_second", req_ready, 4'b0010);
    adv();
    req_valid = '0;
    cyc();
    cyc();
    cyc();

    // Requester 1 gives up before its grant.
    set_req(1, 1'b1, 1'b1, 8'h41, 32'h11);
    set_req(3, 1'b1, 1'b1, 8'h43, 32'h33);
    settle();
    chk("drop_first", req_ready, 4'b1000);
    adv();
    req_valid = '0;
    cyc();
    settle();
    chk("drop_ready", req_ready, 0);
    adv();
    settle();
    chk("drop_idle", psel, 0);
    chk("drop_rsp", rsp_valid, 4'b1000);
    adv();

    // Reset lands during ACCESS of a read by requester 1.
    set_req(1, 1'b1, 1'b0, 8'h51, 32'h0);
    settle();
    chk("abort_grant", req_ready, 4'b0010);
    adv();
    req_valid = '0;
    cyc();
    prdata = 32'hBAD0BAD0;
    preset = 1'b1;
    settle();
    chk("abort_in_access", penable, 1);
    adv();
    preset = 1'b0;
    for (int i = 0; i < N; i++)
      set_req(i, 1'b1, 1'b0, 8'(32'h60 + i), 32'hC0DE0000 + i);
    settle();
    chk("abort_psel", psel, 0);
    chk("abort_penable", penable, 0);
    chk("abort_paddr", paddr, 0);
    chk("abort_rsp", rsp_valid, 0);
    chk("abort_next_grant", req_ready, 4'b0001);
    adv();
    req_valid = '0;
    settle();
    chk("abort_norsp", rsp_valid, 0);
    adv();
    cyc();
    cyc();

    // Idle bus: fields hold from the last transfer.
    for (int c = 0; c < 20; c++) begin
      prdata = $urandom;
      settle();
      chk("idle_psel", psel, 0);
      chk("idle_ready", req_ready, 0);
      chk("idle_rsp", rsp_valid, 0);
      chk("idle_paddr", paddr, 8'h60);
      chk("idle_pwdata", pwdata, 32'hC0DE0000);
      adv();
    end

    // Random traffic with occasional resets.
    granted = '0;
    for (int c = 0; c < 3000; c++) begin
      preset = ($urandom_range(0, 199) == 0);
      prdata = $urandom;
      for (int i = 0; i < N; i++) begin
        if (granted[i] || !req_valid[i]) begin
          if ($urandom_range(0, 2) == 0)
            set_req(i, 1'b1, 1'($urandom_range(0, 1)),
                    8'($urandom), $urandom);
          else
            req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      settle();
      granted = e_ready;
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
